// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with active-low request/grant handshaking.
// Bounded grant tenure stops one master from starving the others, and the
// owner's lock bit suspends tenure preemption. Ownership parks with the last
// owner when nobody requests.
module bus_arbiter_rr #(
   parameter  int NUM_MASTERS = 4,
   parameter  int MAX_TENURE  = 16,
   localparam int OWNER_W     = $clog2(NUM_MASTERS),
   localparam int CNT_W       = ($clog2(MAX_TENURE) > 1) ? $clog2(MAX_TENURE) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_MASTERS-1:0] req_,
   input  logic [NUM_MASTERS-1:0] lock_,
   output logic [NUM_MASTERS-1:0] grnt_,
   output logic [OWNER_W-1:0]     owner,
   output logic                   handover
);

   // Last tenure count value before the owner becomes preemptible.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_TENURE == 0) ? 0 : MAX_TENURE - 1);

   typedef enum logic [2:0] {
      ACT_KEEP,
      ACT_PREEMPT,
      ACT_RELEASE,
      ACT_IDLE,
      ACT_RECOVER
   } act_t;

   act_t               act;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_d;
   logic [OWNER_W-1:0] owner_d;
   logic [OWNER_W-1:0] next_owner;
   logic               handover_d;
   logic               owner_valid;
   logic               own_req;
   logic               locked;
   logic               others;
   logic               expire;
   logic               found;

   // Decode the one-cold grant straight from the owner register.
   always_comb begin
      grnt_ = '1;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (owner == OWNER_W'(i)) begin
            grnt_[i] = 1'b0;
         end
      end
   end

   // Owner's own request/lock, competing requests and tenure expiry.
   always_comb begin
      owner_valid = 1'b0;
      own_req     = 1'b0;
      locked      = 1'b0;
      others      = 1'b0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (owner == OWNER_W'(i)) begin
            owner_valid = 1'b1;
            own_req     = ~req_[i];
            locked      = ~lock_[i];
         end else if (!req_[i]) begin
            others = 1'b1;
         end
      end
      expire = (MAX_TENURE != 0) && (cnt == CNT_LAST);
   end

   // Rotating search from owner+1; modulo wrap keeps non-power-of-two counts correct.
   always_comb begin
      logic [OWNER_W-1:0] idx;
      int unsigned        own_i;
      found      = 1'b0;
      next_owner = owner;
      idx        = '0;
      own_i      = 32'(owner);
      for (int unsigned i = 1; i < NUM_MASTERS; i++) begin
         idx = OWNER_W'((own_i + i) % NUM_MASTERS);
         if (!found && !req_[idx]) begin
            found      = 1'b1;
            next_owner = idx;
         end
      end
   end

   // Select the arbitration action by priority and form the next state.
   always_comb begin
      owner_d    = owner;
      cnt_d      = cnt;
      handover_d = 1'b0;
      if (!owner_valid) begin
         act = ACT_RECOVER;
      end else if (own_req && (!expire || locked || !others)) begin
         act = ACT_KEEP;
      end else if (own_req) begin
         act = ACT_PREEMPT;
      end else if (others) begin
         act = ACT_RELEASE;
      end else begin
         act = ACT_IDLE;
      end

      case (act)
         ACT_KEEP: begin
            cnt_d = expire ? cnt : cnt + CNT_W'(1);
         end
         ACT_PREEMPT, ACT_RELEASE: begin
            owner_d    = next_owner;
            cnt_d      = '0;
            handover_d = 1'b1;
         end
         ACT_IDLE: begin
            cnt_d = '0;
         end
         ACT_RECOVER: begin
            owner_d    = '0;
            cnt_d      = '0;
            handover_d = 1'b1;
         end
         default: begin
            owner_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // State register; synchronous reset returns to master 0 with a fresh tenure.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner    <= '0;
         cnt      <= '0;
         handover <= 1'b0;
      end else begin
         owner    <= owner_d;
         cnt      <= cnt_d;
         handover <= handover_d;
      end
   end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: a stimulus process drives directed
// vectors and queues the hand-computed post-edge state; a monitor pops and
// compares after every rising edge. A second instance with unlimited tenure
// sits in reset until the final phase.
module tb_bus_arbiter_rr;

   typedef struct packed {
      logic [1:0] owner;
      logic [1:0] cnt;
      logic       hand;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req_ = '1;
   logic [3:0] lock_ = '1;
   logic [3:0] grnt_;
   logic [1:0] owner;
   logic       handover;

   logic       reset0 = 1'b1;
   logic [3:0] req0_ = '1;
   logic [3:0] lock0_ = '1;
   logic [3:0] grnt0_;
   logic [1:0] owner0;
   logic       handover0;

   exp_t  exp_q[$];
   string tag_q[$];
   int    total  = 0;
   int    passed = 0;

   bus_arbiter_rr #(.NUM_MASTERS(4), .MAX_TENURE(4)) dut (
      .clk(clk), .reset(reset), .req_(req_), .lock_(lock_),
      .grnt_(grnt_), .owner(owner), .handover(handover)
   );

   bus_arbiter_rr #(.NUM_MASTERS(4), .MAX_TENURE(0)) dut0 (
      .clk(clk), .reset(reset0), .req_(req0_), .lock_(lock0_),
      .grnt_(grnt0_), .owner(owner0), .handover(handover0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s [%s] @%0t: got %0h, expected %0h", name, tag, $time, act, exp);
      end
   endtask

   // One clock of stimulus plus the state expected right after the next edge.
   task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                       input logic r0, input logic [3:0] rq0,
                       input int eo, input int ec, input int eh, input string tag);
      exp_t e;
      @(negedge clk);
      reset  = r;
      req_   = rq;
      lock_  = lk;
      reset0 = r0;
      req0_  = rq0;
      e.owner = 2'(eo);
      e.cnt   = 2'(ec);
      e.hand  = 1'(eh);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // Monitor: compare both instances against the queued expectation.
   initial begin
      exp_t       e;
      string      t;
      logic [3:0] g;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            g = 4'b1111;
            g[e.owner] = 1'b0;
            chk("owner",     t, 32'(owner),     32'(e.owner));
            chk("grnt_",     t, 32'(grnt_),     32'(g));
            chk("handover",  t, 32'(handover),  32'(e.hand));
            chk("cnt",       t, 32'(dut.cnt),   32'(e.cnt));
            chk("owner0",    t, 32'(owner0),    32'd0);
            chk("grnt0_",    t, 32'(grnt0_),    32'hE);
            chk("handover0", t, 32'(handover0), 32'd0);
         end
      end
   end

   // Directed stimulus.
   initial begin
      // Reset with random requests and locks.
      for (int k = 0; k < 2; k++)
         step(1'b1, 4'($urandom), 4'($urandom), 1'b1, 4'b1111, 0, 0, 0, "reset");

      // Full contention: four cycles per owner, handover on each change.
      for (int s = 1; s <= 20; s++)
         step(1'b0, 4'b0000, 4'b1111, 1'b1, 4'b1111, (s / 4) % 4, s % 4, (s % 4 == 0) ? 1 : 0, "rotate");

      // Owner 1 locked: tenure saturates, no preemption; unlock hands to 2.
      for (int k = 1; k <= 10; k++)
         step(1'b0, 4'b0000, 4'b1101, 1'b1, 4'b1111, 1, (k < 3) ? k : 3, 0, "lock");
      step(1'b0, 4'b0000, 4'b1111, 1'b1, 4'b1111, 2, 0, 1, "unlock");

      // Lock held by a non-owner does not stop preemption of owner 2.
      step(1'b0, 4'b0000, 4'b1101, 1'b1, 4'b1111, 2, 1, 0, "lock_other");
      step(1'b0, 4'b0000, 4'b1101, 1'b1, 4'b1111, 2, 2, 0, "lock_other");
      step(1'b0, 4'b0000, 4'b1101, 1'b1, 4'b1111, 2, 3, 0, "lock_other");
      step(1'b0, 4'b0000, 4'b1101, 1'b1, 4'b1111, 3, 0, 1, "lock_other");

      // Owner 3 releases to lone requester 2; build cnt = 2, then reset.
      step(1'b0, 4'b1011, 4'b1111, 1'b1, 4'b1111, 2, 0, 1, "release");
      step(1'b0, 4'b1011, 4'b1111, 1'b1, 4'b1111, 2, 1, 0, "lone_keep");
      step(1'b0, 4'b1011, 4'b1111, 1'b1, 4'b1111, 2, 2, 0, "lone_keep");
      step(1'b1, 4'b1011, 4'b1111, 1'b1, 4'b1111, 0, 0, 0, "mid_reset");

      // Park with no requests, then a lone request from master 3.
      for (int k = 0; k < 3; k++)
         step(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1111, 0, 0, 0, "park");
      step(1'b0, 4'b0111, 4'b1111, 1'b1, 4'b1111, 3, 0, 1, "lone_req");
      for (int k = 1; k <= 6; k++)
         step(1'b0, 4'b0111, 4'b1111, 1'b1, 4'b1111, 3, (k < 3) ? k : 3, 0, "lone_hold");

      // 3 releases while 0 and 2 request: wraps to 0, later skips 1 for 2.
      step(1'b0, 4'b1010, 4'b1111, 1'b1, 4'b1111, 0, 0, 1, "wrap");
      step(1'b0, 4'b1010, 4'b1111, 1'b1, 4'b1111, 0, 1, 0, "wrap_keep");
      step(1'b0, 4'b1010, 4'b1111, 1'b1, 4'b1111, 0, 2, 0, "wrap_keep");
      step(1'b0, 4'b1010, 4'b1111, 1'b1, 4'b1111, 0, 3, 0, "wrap_keep");
      step(1'b0, 4'b1010, 4'b1111, 1'b1, 4'b1111, 2, 0, 1, "skip");

      // Locked owner 2 dropping its request still releases, wrapping to 0.
      step(1'b0, 4'b1110, 4'b1011, 1'b1, 4'b1111, 0, 0, 1, "locked_release");

      // Unlimited-tenure instance under full contention never rotates.
      for (int k = 1; k <= 100; k++)
         step(1'b0, 4'b1110, 4'b1111, 1'b0, 4'b0000, 0, (k < 3) ? k : 3, 0, "unlimited");

      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", "end", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("%0d/%0d checks passed", passed, total + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
